ibex_ex_issue_ctrl: RTL and testbench

IBEX_EX_ISSUE_CTRL -- requirements
Module: ibex_ex_issue_ctrl

---
 rtl/ibex_ex_issue_ctrl_pkg.sv | 48 ++++
 rtl/ibex_ex_issue_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ibex_ex_issue_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_ex_issue_ctrl_pkg.sv
// Shared types for the EX issue controller: op classes, FSM states, request payload.
package ibex_ex_issue_ctrl_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned OP_TYPE_W = 2;
  localparam int unsigned ALU_OP_W  = 7;
  localparam int unsigned MD_OP_W   = 2;
  localparam int unsigned MD_SIGN_W = 2;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned IMD_W     = 34;
  localparam int unsigned IMD_BUS_W = 2 * IMD_W;

  typedef enum int {
    RV32MNone        = 0,
    RV32MSlow        = 1,
    RV32MFast        = 2,
    RV32MSingleCycle = 3
  } rv32m_e;

  typedef enum logic [OP_TYPE_W-1:0] {
    OpAlu  = 2'd0,
    OpMult = 2'd1,
    OpDiv  = 2'd2,
    OpRsvd = 2'd3
  } op_type_e;

  typedef enum logic [1:0] {
    IssueIdle = 2'd0,
    IssueExec = 2'd1,
    IssueWb   = 2'd2
  } issue_state_e;

  typedef struct packed {
    op_type_e               op_type;
    logic [ALU_OP_W-1:0]    alu_operator;
    logic [XLEN-1:0]        operand_a;
    logic [XLEN-1:0]        operand_b;
    logic [MD_OP_W-1:0]     multdiv_operator;
    logic [MD_SIGN_W-1:0]   multdiv_signed_mode;
    logic [RF_ADDR_W-1:0]   rd_addr;
  } issue_req_t;

  // Reserved op type falls back to ALU, so only MULT/DIV count as multdiv ops.
  function automatic logic is_md_op(input op_type_e op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/ibex_ex_issue_ctrl.sv
// Issue controller in front of the EX block: latches one request, steers it to
// ALU or multdiv, tracks the multdiv intermediate registers and holds writeback.
module ibex_ex_issue_ctrl
  import ibex_ex_issue_ctrl_pkg::*;
#(
  parameter int RV32M         = 32'sd2,
  parameter bit DataIndTiming = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [OP_TYPE_W-1:0]  op_type_i,
  input  logic [ALU_OP_W-1:0]   alu_operator_i,
  input  logic [XLEN-1:0]       operand_a_i,
  input  logic [XLEN-1:0]       operand_b_i,
  input  logic [MD_OP_W-1:0]    multdiv_operator_i,
  input  logic [MD_SIGN_W-1:0]  multdiv_signed_mode_i,
  input  logic [RF_ADDR_W-1:0]  rd_addr_i,

  output logic [ALU_OP_W-1:0]   alu_operator_o,
  output logic [XLEN-1:0]       alu_operand_a_o,
  output logic [XLEN-1:0]       alu_operand_b_o,
  output logic                  alu_instr_first_cycle_o,
  output logic [MD_OP_W-1:0]    multdiv_operator_o,
  output logic [MD_SIGN_W-1:0]  multdiv_signed_mode_o,
  output logic [XLEN-1:0]       multdiv_operand_a_o,
  output logic [XLEN-1:0]       multdiv_operand_b_o,
  output logic                  mult_en_o,
  output logic                  div_en_o,
  output logic                  mult_sel_o,
  output logic                  div_sel_o,
  output logic                  multdiv_ready_id_o,
  output logic                  data_ind_timing_o,
  output logic [IMD_BUS_W-1:0]  imd_val_q_o,

  input  logic [1:0]            imd_val_we_i,
  input  logic [IMD_BUS_W-1:0]  imd_val_d_i,
  input  logic [XLEN-1:0]       result_ex_i,
  input  logic                  ex_valid_i,

  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [RF_ADDR_W-1:0]  wb_rd_addr_o,
  output logic [XLEN-1:0]       wb_result_o,
  output logic                  wb_err_o,
  input  logic                  flush_i
);

  localparam bit MdEnabled = (RV32M != int'(RV32MNone));

  issue_state_e         state_q, state_d;
  issue_req_t           req_q, req_d;
  logic                 first_q, first_d;
  logic [XLEN-1:0]      wb_result_q, wb_result_d;
  logic [RF_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                 wb_err_q, wb_err_d;
  logic [IMD_W-1:0]     imd0_q, imd0_d, imd1_q, imd1_d;

  logic accept;
  logic md_illegal;
  logic exec_mult;
  logic exec_div;

  // Multdiv ops without a multdiv unit complete as an error instead of issuing.
  assign md_illegal = !MdEnabled && is_md_op(req_q.op_type);
  assign exec_mult  = MdEnabled && (req_q.op_type == OpMult);
  assign exec_div   = MdEnabled && (req_q.op_type == OpDiv);

  // Next-state, request capture and handshake outputs.
  always_comb begin
    state_d                 = state_q;
    req_d                   = req_q;
    first_d                 = first_q;
    wb_result_d             = wb_result_q;
    wb_rd_d                 = wb_rd_q;
    wb_err_d                = wb_err_q;
    instr_ready_o           = 1'b0;
    wb_valid_o              = 1'b0;
    multdiv_ready_id_o      = 1'b0;
    alu_instr_first_cycle_o = 1'b0;
    mult_sel_o              = 1'b0;
    mult_en_o               = 1'b0;
    div_sel_o               = 1'b0;
    div_en_o                = 1'b0;
    accept                  = 1'b0;

    unique case (state_q)
      IssueIdle: begin
        instr_ready_o = 1'b1;
      end
      IssueExec: begin
        multdiv_ready_id_o      = 1'b1;
        alu_instr_first_cycle_o = first_q;
        mult_sel_o              = exec_mult;
        mult_en_o               = exec_mult;
        div_sel_o               = exec_div;
        div_en_o                = exec_div;
        first_d                 = 1'b0;
        if (md_illegal) begin
          wb_result_d = '0;
          wb_rd_d     = req_q.rd_addr;
          wb_err_d    = 1'b1;
          state_d     = IssueWb;
        end else if (ex_valid_i) begin
          wb_result_d = result_ex_i;
          wb_rd_d     = req_q.rd_addr;
          wb_err_d    = 1'b0;
          state_d     = IssueWb;
        end
      end
      IssueWb: begin
        wb_valid_o    = 1'b1;
        instr_ready_o = wb_ready_i;
        if (wb_ready_i) begin
          state_d = IssueIdle;
        end
      end
      default: begin
        state_d = IssueIdle;
      end
    endcase

    if (flush_i) begin
      instr_ready_o = 1'b0;
      wb_valid_o    = 1'b0;
    end

    accept = instr_valid_i && instr_ready_o;
    if (accept) begin
      req_d = '{
        op_type:             op_type_e'(op_type_i),
        alu_operator:        alu_operator_i,
        operand_a:           operand_a_i,
        operand_b:           operand_b_i,
        multdiv_operator:    multdiv_operator_i,
        multdiv_signed_mode: multdiv_signed_mode_i,
        rd_addr:             rd_addr_i
      };
      first_d = 1'b1;
      state_d = IssueExec;
    end

    if (flush_i) begin
      state_d = IssueIdle;
      first_d = 1'b0;
    end
  end

  // Intermediate words load independently of the FSM, flush does not touch them.
  always_comb begin
    imd0_d = imd0_q;
    imd1_d = imd1_q;
    if (imd_val_we_i[0]) imd0_d = imd_val_d_i[IMD_W-1:0];
    if (imd_val_we_i[1]) imd1_d = imd_val_d_i[IMD_BUS_W-1:IMD_W];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IssueIdle;
      req_q       <= '0;
      first_q     <= 1'b0;
      wb_result_q <= '0;
      wb_rd_q     <= '0;
      wb_err_q    <= 1'b0;
      imd0_q      <= '0;
      imd1_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      first_q     <= first_d;
      wb_result_q <= wb_result_d;
      wb_rd_q     <= wb_rd_d;
      wb_err_q    <= wb_err_d;
      imd0_q      <= imd0_d;
      imd1_q      <= imd1_d;
    end
  end

  assign alu_operator_o        = req_q.alu_operator;
  assign alu_operand_a_o       = req_q.operand_a;
  assign alu_operand_b_o       = req_q.operand_b;
  assign multdiv_operator_o    = req_q.multdiv_operator;
  assign multdiv_signed_mode_o = req_q.multdiv_signed_mode;
  assign multdiv_operand_a_o   = req_q.operand_a;
  assign multdiv_operand_b_o   = req_q.operand_b;
  assign data_ind_timing_o     = DataIndTiming;
  assign imd_val_q_o           = {imd1_q, imd0_q};
  assign wb_rd_addr_o          = wb_rd_q;
  assign wb_result_o           = wb_result_q;
  assign wb_err_o              = wb_err_q;

endmodule

// File: tb/tb_ibex_ex_issue_ctrl.sv
// Directed plus randomized bench for ibex_ex_issue_ctrl with a transaction-level model.
module tb_ibex_ex_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        instr_valid_i = 1'b0;
  logic [1:0]  op_type_i = '0;
  logic [6:0]  alu_operator_i = '0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic [1:0]  multdiv_operator_i = '0;
  logic [1:0]  multdiv_signed_mode_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic [1:0]  imd_val_we_i = '0;
  logic [67:0] imd_val_d_i = '0;
  logic [31:0] result_ex_i = '0;
  logic        ex_valid_i = 1'b0;
  logic        wb_ready_i = 1'b0;
  logic        flush_i = 1'b0;

  logic        instr_ready_o, alu_instr_first_cycle_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o;
  logic        multdiv_ready_id_o, data_ind_timing_o, wb_valid_o, wb_err_o;
  logic [6:0]  alu_operator_o;
  logic [31:0] alu_operand_a_o, alu_operand_b_o, multdiv_operand_a_o, multdiv_operand_b_o, wb_result_o;
  logic [1:0]  multdiv_operator_o, multdiv_signed_mode_o;
  logic [67:0] imd_val_q_o;
  logic [4:0]  wb_rd_addr_o;

  logic        instr_ready_n, first_n, mult_en_n, div_en_n, mult_sel_n, div_sel_n;
  logic        ready_id_n, dit_n, wb_valid_n, wb_err_n;
  logic [6:0]  alu_operator_n;
  logic [31:0] alu_a_n, alu_b_n, md_a_n, md_b_n, wb_result_n;
  logic [1:0]  md_op_n, md_sign_n;
  logic [67:0] imd_n;
  logic [4:0]  wb_rd_n;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  ibex_ex_issue_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .op_type_i(op_type_i),
    .alu_operator_i(alu_operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .multdiv_operator_i(multdiv_operator_i), .multdiv_signed_mode_i(multdiv_signed_mode_i),
    .rd_addr_i(rd_addr_i),
    .alu_operator_o(alu_operator_o), .alu_operand_a_o(alu_operand_a_o),
    .alu_operand_b_o(alu_operand_b_o), .alu_instr_first_cycle_o(alu_instr_first_cycle_o),
    .multdiv_operator_o(multdiv_operator_o), .multdiv_signed_mode_o(multdiv_signed_mode_o),
    .multdiv_operand_a_o(multdiv_operand_a_o), .multdiv_operand_b_o(multdiv_operand_b_o),
    .mult_en_o(mult_en_o), .div_en_o(div_en_o), .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
    .multdiv_ready_id_o(multdiv_ready_id_o), .data_ind_timing_o(data_ind_timing_o),
    .imd_val_q_o(imd_val_q_o), .imd_val_we_i(imd_val_we_i), .imd_val_d_i(imd_val_d_i),
    .result_ex_i(result_ex_i), .ex_valid_i(ex_valid_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_addr_o(wb_rd_addr_o),
    .wb_result_o(wb_result_o), .wb_err_o(wb_err_o), .flush_i(flush_i)
  );

  ibex_ex_issue_ctrl #(.RV32M(0), .DataIndTiming(1'b1)) dut_nm (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_n), .op_type_i(op_type_i),
    .alu_operator_i(alu_operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .multdiv_operator_i(multdiv_operator_i), .multdiv_signed_mode_i(multdiv_signed_mode_i),
    .rd_addr_i(rd_addr_i),
    .alu_operator_o(alu_operator_n), .alu_operand_a_o(alu_a_n),
    .alu_operand_b_o(alu_b_n), .alu_instr_first_cycle_o(first_n),
    .multdiv_operator_o(md_op_n), .multdiv_signed_mode_o(md_sign_n),
    .multdiv_operand_a_o(md_a_n), .multdiv_operand_b_o(md_b_n),
    .mult_en_o(mult_en_n), .div_en_o(div_en_n), .mult_sel_o(mult_sel_n), .div_sel_o(div_sel_n),
    .multdiv_ready_id_o(ready_id_n), .data_ind_timing_o(dit_n),
    .imd_val_q_o(imd_n), .imd_val_we_i(imd_val_we_i), .imd_val_d_i(imd_val_d_i),
    .result_ex_i(result_ex_i), .ex_valid_i(ex_valid_i),
    .wb_valid_o(wb_valid_n), .wb_ready_i(wb_ready_i), .wb_rd_addr_o(wb_rd_n),
    .wb_result_o(wb_result_n), .wb_err_o(wb_err_n), .flush_i(flush_i)
  );

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    instr_valid_i         = 1'b1;
    op_type_i             = op;
    alu_operator_i        = 7'($urandom);
    operand_a_i           = a;
    operand_b_i           = b;
    multdiv_operator_i    = 2'($urandom);
    multdiv_signed_mode_i = 2'($urandom);
    rd_addr_i             = rd;
  endtask

  function automatic logic [67:0] rand68();
    return {4'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [67:0] imd_model;
    logic [67:0] d;
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [1:0]  op;
    logic [1:0]  we;
    int          lat;
    int          stall;

    // Async reset assertion without a clock edge.
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_err", wb_err_o, 0);
    chk("rst_wb_result", wb_result_o, 0);
    chk("rst_imd", imd_val_q_o, 0);
    chk("rst_first", alu_instr_first_cycle_o, 0);
    chk("rst_ready_id", multdiv_ready_id_o, 0);
    chk("rst_sel_en", {mult_en_o, div_en_o, mult_sel_o, div_sel_o}, 0);
    chk("rst_operand_a", alu_operand_a_o, 0);
    chk("rst_instr_ready", instr_ready_o, 1);
    chk("dit_default", data_ind_timing_o, 0);
    chk("dit_param", dit_n, 1);
    tick();
    rst_ni = 1'b1;
    tick();

    // ex_valid_i in IDLE is ignored.
    ex_valid_i = 1'b1; result_ex_i = 32'h55;
    tick();
    ex_valid_i = 1'b0; #1;
    chk("ex_valid_idle_ignored", wb_valid_o, 0);

    // Flush beats a simultaneous request.
    flush_i = 1'b1; issue(2'd0, 32'd1, 32'd2, 5'd1); #1;
    chk("flush_blocks_ready", instr_ready_o, 0);
    tick();
    flush_i = 1'b0; instr_valid_i = 1'b0; #1;
    chk("flush_no_accept", {multdiv_ready_id_o, alu_instr_first_cycle_o}, 0);

    // ALU ADD 5+7, result in the first EXEC cycle.
    issue(2'd0, 32'd5, 32'd7, 5'd3); alu_operator_i = 7'd0; #1;
    chk("add_ready_idle", instr_ready_o, 1);
    tick();
    instr_valid_i = 1'b0; ex_valid_i = 1'b1; result_ex_i = 32'd12; #1;
    chk("add_first", alu_instr_first_cycle_o, 1);
    chk("add_ops", {alu_operand_a_o, alu_operand_b_o}, {32'd5, 32'd7});
    chk("add_md_ops", {multdiv_operand_a_o, multdiv_operand_b_o}, {32'd5, 32'd7});
    chk("add_alu_op", alu_operator_o, 0);
    chk("add_ready_id", multdiv_ready_id_o, 1);
    chk("add_no_md", {mult_en_o, div_en_o, mult_sel_o, div_sel_o}, 0);
    chk("add_no_wb_yet", wb_valid_o, 0);
    chk("add_busy", instr_ready_o, 0);
    tick();
    ex_valid_i = 1'b0; wb_ready_i = 1'b1; #1;
    chk("add_wb_valid", wb_valid_o, 1);
    chk("add_wb_result", wb_result_o, 32'd12);
    chk("add_wb_rd", wb_rd_addr_o, 3);
    chk("add_wb_err", wb_err_o, 0);
    chk("add_first_once", alu_instr_first_cycle_o, 0);
    chk("add_ready_wb", instr_ready_o, 1);
    tick();
    wb_ready_i = 1'b0; #1;
    chk("add_wb_one_cycle", wb_valid_o, 0);

    // DIV with three intermediate-register cycles.
    issue(2'd2, 32'd100, 32'd7, 5'd9); multdiv_operator_i = 2'd2; multdiv_signed_mode_i = 2'b11;
    tick();
    instr_valid_i = 1'b0;
    d = '0;
    for (int k = 0; k < 3; k++) begin
      d = rand68();
      imd_val_we_i = 2'b11; imd_val_d_i = d; #1;
      chk("div_sel", {div_sel_o, div_en_o, mult_sel_o, mult_en_o}, 4'b1100);
      chk("div_first", alu_instr_first_cycle_o, (k == 0));
      chk("div_md_fields", {multdiv_operator_o, multdiv_signed_mode_o}, 4'b1011);
      tick();
      chk("div_imd_track", imd_val_q_o, d);
    end
    imd_val_we_i = 2'b00; ex_valid_i = 1'b1; result_ex_i = 32'd14; #1;
    chk("div_sel_last", div_sel_o, 1);
    chk("div_first_last", alu_instr_first_cycle_o, 0);
    tick();
    ex_valid_i = 1'b0; #1;
    chk("div_wb", {wb_valid_o, wb_result_o, wb_rd_addr_o}, {1'b1, 32'd14, 5'd9});
    chk("div_sel_off", div_sel_o, 0);
    chk("div_imd_hold", imd_val_q_o, d);
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;

    // Writeback stall with 0xDEADBEEF.
    issue(2'd0, 32'd1, 32'd1, 5'd4);
    tick();
    instr_valid_i = 1'b0; ex_valid_i = 1'b1; result_ex_i = 32'hDEADBEEF;
    tick();
    ex_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_wb", {wb_valid_o, wb_result_o, wb_rd_addr_o}, {1'b1, 32'hDEADBEEF, 5'd4});
      chk("stall_not_ready", instr_ready_o, 0);
      tick();
    end
    wb_ready_i = 1'b1; #1;
    chk("stall_handshake_ready", instr_ready_o, 1);
    tick();
    wb_ready_i = 1'b0; #1;
    chk("stall_released", wb_valid_o, 0);

    // Back-to-back: new op accepted during the WB handshake.
    issue(2'd0, 32'h11, 32'h22, 5'd5);
    tick();
    instr_valid_i = 1'b0; ex_valid_i = 1'b1; result_ex_i = 32'h111;
    tick();
    ex_valid_i = 1'b0; wb_ready_i = 1'b1; issue(2'd3, 32'hAA, 32'hBB, 5'd6); #1;
    chk("b2b_ready", instr_ready_o, 1);
    chk("b2b_wb_first", {wb_valid_o, wb_result_o}, {1'b1, 32'h111});
    tick();
    instr_valid_i = 1'b0; wb_ready_i = 1'b0; #1;
    chk("b2b_exec", {multdiv_ready_id_o, alu_instr_first_cycle_o, wb_valid_o}, 3'b110);
    chk("b2b_operand", alu_operand_a_o, 32'hAA);
    ex_valid_i = 1'b1; result_ex_i = 32'h222;
    tick();
    ex_valid_i = 1'b0; #1;
    chk("b2b_wb_second", {wb_valid_o, wb_result_o, wb_rd_addr_o}, {1'b1, 32'h222, 5'd6});
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;

    // Flush in the third EXEC cycle of a MULT.
    issue(2'd1, 32'd3, 32'd4, 5'd7);
    tick();
    instr_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("mult_en_exec", {mult_en_o, mult_sel_o}, 2'b11);
      tick();
    end
    flush_i = 1'b1; #1;
    chk("flush_cycle_mult_en", mult_en_o, 1);
    tick();
    flush_i = 1'b0; #1;
    chk("flush_idle", {multdiv_ready_id_o, mult_en_o, mult_sel_o, wb_valid_o}, 0);
    chk("flush_ready", instr_ready_o, 1);
    chk("flush_imd_kept", imd_val_q_o, d);
    ex_valid_i = 1'b1;
    tick();
    ex_valid_i = 1'b0; #1;
    chk("flush_no_wb", wb_valid_o, 0);

    // Reset in EXEC and in WB discards the op.
    issue(2'd0, 32'd9, 32'd9, 5'd8);
    tick();
    instr_valid_i = 1'b0; rst_ni = 1'b0; #1;
    chk("rst_exec_ready_id", multdiv_ready_id_o, 0);
    tick();
    rst_ni = 1'b1; ex_valid_i = 1'b1;
    tick();
    ex_valid_i = 1'b0; #1;
    chk("rst_exec_no_wb", wb_valid_o, 0);
    issue(2'd0, 32'd9, 32'd9, 5'd8);
    tick();
    instr_valid_i = 1'b0; ex_valid_i = 1'b1; result_ex_i = 32'h77;
    tick();
    ex_valid_i = 1'b0; rst_ni = 1'b0; #1;
    chk("rst_wb_drop", {wb_valid_o, wb_result_o}, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("rst_wb_after", wb_valid_o, 0);

    // Randomized transactions against the scoreboard model.
    imd_model = rand68();
    imd_val_we_i = 2'b11; imd_val_d_i = imd_model;
    tick();
    imd_val_we_i = 2'b00;
    chk("rnd_imd_init", imd_val_q_o, imd_model);
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom); res = $urandom;
      lat = $urandom_range(0, 3); stall = $urandom_range(0, 3);
      issue(op, a, b, rd); #1;
      chk("rnd_ready", instr_ready_o, 1);
      tick();
      instr_valid_i = 1'b0;
      for (int c = 0; c <= lat; c++) begin
        we = 2'($urandom); d = rand68();
        imd_val_we_i = we; imd_val_d_i = d;
        ex_valid_i = (c == lat); result_ex_i = (c == lat) ? res : $urandom; #1;
        chk("rnd_first", alu_instr_first_cycle_o, (c == 0));
        chk("rnd_sel", {mult_sel_o, div_sel_o}, {op == 2'd1, op == 2'd2});
        chk("rnd_operands", {multdiv_operand_a_o, alu_operand_b_o}, {a, b});
        chk("rnd_no_wb", wb_valid_o, 0);
        tick();
        if (we[0]) imd_model[33:0] = d[33:0];
        if (we[1]) imd_model[67:34] = d[67:34];
        chk("rnd_imd", imd_val_q_o, imd_model);
      end
      ex_valid_i = 1'b0;
      for (int s = 0; s <= stall; s++) begin
        we = 2'($urandom); d = rand68();
        imd_val_we_i = we; imd_val_d_i = d;
        wb_ready_i = (s == stall); #1;
        chk("rnd_wb", {wb_valid_o, wb_err_o, wb_result_o, wb_rd_addr_o}, {2'b10, res, rd});
        chk("rnd_wb_ready", instr_ready_o, (s == stall));
        tick();
        if (we[0]) imd_model[33:0] = d[33:0];
        if (we[1]) imd_model[67:34] = d[67:34];
        chk("rnd_imd_wb", imd_val_q_o, imd_model);
      end
      wb_ready_i = 1'b0; imd_val_we_i = 2'b00;
    end

    // No multdiv unit: MULT completes as an error without issuing.
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    issue(2'd1, 32'd6, 32'd7, 5'd10);
    tick();
    instr_valid_i = 1'b0; #1;
    chk("nm_no_sel", {mult_sel_n, mult_en_n, div_sel_n, div_en_n}, 0);
    chk("nm_ready_id", ready_id_n, 1);
    chk("m_has_sel", mult_sel_o, 1);
    tick();
    chk("nm_wb", {wb_valid_n, wb_err_n, wb_result_n, wb_rd_n}, {2'b11, 32'd0, 5'd10});
    chk("nm_no_sel_wb", mult_sel_n, 0);
    wb_ready_i = 1'b1; flush_i = 1'b1;
    tick();
    wb_ready_i = 1'b0; flush_i = 1'b0; #1;
    chk("nm_done", {wb_valid_n, wb_valid_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
